// File: rtl/motoro3_gate_monitor.sv
// Independent checker for the six bridge gate drives: recovers the 6-step index,
// direction and step period, and latches shoot-through / dead-time faults.
module motoro3_gate_monitor #(
    parameter int DEAD_MIN     = 4,
    parameter int STABLE_MIN   = 8,
    parameter int CNT_W        = 25,
    parameter int STALL_CYCLES = 10000000
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             aHp,
    input  logic             aLp,
    input  logic             bHp,
    input  logic             bLp,
    input  logic             cHp,
    input  logic             cLp,
    input  logic             faultClr,
    output logic [2:0]       stepIdx,
    output logic             stepValid,
    output logic             stepDir,
    output logic             stepErr,
    output logic [CNT_W-1:0] stepPeriod,
    output logic             stalled,
    output logic             faultShoot,
    output logic             faultDead,
    output logic [2:0]       faultPhase
);

    localparam int ZW = $clog2(DEAD_MIN + 1);
    localparam int SW = $clog2(STABLE_MIN + 1);

    localparam logic [ZW-1:0]    DEAD_LIM    = ZW'(DEAD_MIN);
    localparam logic [SW-1:0]    STAB_ACCEPT = SW'(STABLE_MIN - 1);
    localparam logic [SW-1:0]    STAB_SAT    = SW'(STABLE_MIN);
    localparam logic [CNT_W-1:0] STALL_VAL   = CNT_W'(STALL_CYCLES);

    // Input stage: everything downstream sees only these registered copies.
    logic [2:0] r_hp;
    logic [2:0] r_lp;
    logic       r_clr;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_hp  <= '0;
            r_lp  <= '0;
            r_clr <= 1'b0;
        end else begin
            r_hp  <= {cHp, bHp, aHp};
            r_lp  <= {cLp, bLp, aLp};
            r_clr <= faultClr;
        end
    end

    logic [2:0] r_held;
    logic [2:0] w_is_h;
    logic [2:0] w_is_l;
    logic [2:0] w_is_z;
    logic [2:0] w_is_x;
    logic [2:0] w_held_next;
    logic [2:0] w_dead_hit;

    for (genvar gi = 0; gi < 3; gi++) begin : g_phase
        logic [ZW-1:0] r_zcnt;

        assign w_is_h[gi] = r_hp[gi] & ~r_lp[gi];
        assign w_is_l[gi] = r_lp[gi] & ~r_hp[gi];
        assign w_is_z[gi] = ~r_hp[gi] & ~r_lp[gi];
        assign w_is_x[gi] = r_hp[gi] & r_lp[gi];

        assign w_held_next[gi] = w_is_h[gi] ? 1'b1 :
                                 w_is_l[gi] ? 1'b0 : r_held[gi];

        // A swap to the opposite level needs DEAD_MIN idle cycles before it.
        assign w_dead_hit[gi] = ((w_is_h[gi] & ~r_held[gi]) | (w_is_l[gi] & r_held[gi]))
                                & (r_zcnt < DEAD_LIM);

        always_ff @(posedge clk or negedge nRst) begin
            if (!nRst) begin
                r_zcnt <= '0;
            end else if (w_is_z[gi]) begin
                if (r_zcnt != DEAD_LIM) begin
                    r_zcnt <= r_zcnt + ZW'(1);
                end
            end else begin
                r_zcnt <= '0;
            end
        end
    end

    logic       r_fault_shoot;
    logic       r_fault_dead;
    logic [2:0] r_fault_phase;
    logic [2:0] w_new_phase;

    assign w_new_phase = w_is_x | w_dead_hit;

    // Clear and a fresh fault in the same cycle: the fresh fault survives.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_fault_shoot <= 1'b0;
            r_fault_dead  <= 1'b0;
            r_fault_phase <= '0;
        end else if (r_clr) begin
            r_fault_shoot <= |w_is_x;
            r_fault_dead  <= |w_dead_hit;
            r_fault_phase <= w_new_phase;
        end else begin
            r_fault_shoot <= r_fault_shoot | (|w_is_x);
            r_fault_dead  <= r_fault_dead | (|w_dead_hit);
            r_fault_phase <= r_fault_phase | w_new_phase;
        end
    end

    function automatic logic [3:0] decode_pattern(input logic [2:0] pat);
        logic [3:0] res;
        res = 4'b0000;
        case (pat)
            3'b001:  res = {1'b1, 3'd0};
            3'b011:  res = {1'b1, 3'd1};
            3'b010:  res = {1'b1, 3'd2};
            3'b110:  res = {1'b1, 3'd3};
            3'b100:  res = {1'b1, 3'd4};
            3'b101:  res = {1'b1, 3'd5};
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    logic [SW-1:0]    r_stab;
    logic             r_locked;
    logic [2:0]       r_idx;
    logic             r_dir;
    logic             r_valid;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic             r_stalled;

    logic [3:0]       w_dec;
    logic             w_cand_ok;
    logic [2:0]       w_cand_idx;
    logic [SW-1:0]    w_stab;
    logic             w_accept;
    logic [2:0]       w_fwd_idx;
    logic [2:0]       w_rev_idx;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_dec      = decode_pattern(w_held_next);
    assign w_cand_ok  = w_dec[3];
    assign w_cand_idx = w_dec[2:0];

    // r_held is exactly the previous cycle's candidate.
    assign w_stab = (w_held_next != r_held) ? '0 :
                    (r_stab == STAB_SAT)    ? r_stab : r_stab + SW'(1);

    assign w_accept  = (w_stab == STAB_ACCEPT) && w_cand_ok &&
                       ((w_cand_idx != r_idx) || !r_locked);
    assign w_fwd_idx = (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
    assign w_rev_idx = (r_idx == 3'd0) ? 3'd5 : r_idx - 3'd1;
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_held    <= '0;
            r_stab    <= '0;
            r_locked  <= 1'b0;
            r_idx     <= '0;
            r_dir     <= 1'b0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_period  <= '0;
            r_stalled <= 1'b0;
        end else begin
            r_held  <= w_held_next;
            r_stab  <= w_stab;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_accept) begin
                r_idx <= w_cand_idx;
                r_cnt <= CNT_W'(1);
                if (!r_locked) begin
                    r_locked <= 1'b1;
                end else begin
                    r_period  <= r_cnt;
                    r_stalled <= 1'b0;
                    if (w_cand_idx == w_fwd_idx) begin
                        r_dir   <= 1'b0;
                        r_valid <= 1'b1;
                    end else if (w_cand_idx == w_rev_idx) begin
                        r_dir   <= 1'b1;
                        r_valid <= 1'b1;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
            end else if (r_locked) begin
                r_cnt <= w_cnt_inc;
                if (w_cnt_inc == STALL_VAL) begin
                    r_stalled <= 1'b1;
                end
            end
        end
    end

    assign stepIdx    = r_idx;
    assign stepValid  = r_valid;
    assign stepDir    = r_dir;
    assign stepErr    = r_err;
    assign stepPeriod = r_period;
    assign stalled    = r_stalled;
    assign faultShoot = r_fault_shoot;
    assign faultDead  = r_fault_dead;
    assign faultPhase = r_fault_phase;

endmodule

// File: tb/tb_motoro3_gate_monitor.sv
// Directed bench for motoro3_gate_monitor: step pulses are checked by a queue-driven
// monitor, faults / stall / reset behaviour are checked inline by the stimulus.
`timescale 1ns/1ps
module tb_motoro3_gate_monitor;

    localparam int CNT_W = 25;
    localparam logic [1:0] PH_H = 2'b10;
    localparam logic [1:0] PH_L = 2'b01;
    localparam logic [1:0] PH_Z = 2'b00;
    localparam logic [1:0] PH_X = 2'b11;

    logic             clk;
    logic             nRst;
    logic [2:0]       g_hp;
    logic [2:0]       g_lp;
    logic             faultClr;
    logic [2:0]       stepIdx;
    logic             stepValid;
    logic             stepDir;
    logic             stepErr;
    logic [CNT_W-1:0] stepPeriod;
    logic             stalled;
    logic             faultShoot;
    logic             faultDead;
    logic [2:0]       faultPhase;

    motoro3_gate_monitor #(
        .DEAD_MIN    (4),
        .STABLE_MIN  (8),
        .CNT_W       (CNT_W),
        .STALL_CYCLES(50)
    ) dut (
        .clk       (clk),
        .nRst      (nRst),
        .aHp       (g_hp[0]),
        .aLp       (g_lp[0]),
        .bHp       (g_hp[1]),
        .bLp       (g_lp[1]),
        .cHp       (g_hp[2]),
        .cLp       (g_lp[2]),
        .faultClr  (faultClr),
        .stepIdx   (stepIdx),
        .stepValid (stepValid),
        .stepDir   (stepDir),
        .stepErr   (stepErr),
        .stepPeriod(stepPeriod),
        .stalled   (stalled),
        .faultShoot(faultShoot),
        .faultDead (faultDead),
        .faultPhase(faultPhase)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    typedef struct {
        bit err;
        int idx;
        bit dir;
        int period;
        bit chk_period;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_err    = 0;
    logic [2:0] tb_pat   = 3'b000;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic logic [2:0] pat_of(input int idx);
        logic [2:0] p;
        case (idx)
            0: p = 3'b001;
            1: p = 3'b011;
            2: p = 3'b010;
            3: p = 3'b110;
            4: p = 3'b100;
            default: p = 3'b101;
        endcase
        return p;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ph(input int ph, input logic [1:0] v);
        g_hp[ph] = v[1];
        g_lp[ph] = v[0];
    endtask

    task automatic push_exp(input bit err, input int idx, input bit dir, input int period, input bit chk);
        exp_t e;
        e.err = err; e.idx = idx; e.dir = dir; e.period = period; e.chk_period = chk;
        sb.push_back(e);
    endtask

    // 4-cycle Z gap on changing phases, then the new pattern; hold counts the gap.
    task automatic goto_step(input int idx, input int hold);
        logic [2:0] nxt;
        nxt = pat_of(idx);
        for (int ph = 0; ph < 3; ph++)
            if (nxt[ph] != tb_pat[ph]) set_ph(ph, PH_Z);
        tick(4);
        for (int ph = 0; ph < 3; ph++)
            set_ph(ph, nxt[ph] ? PH_H : PH_L);
        tb_pat = nxt;
        tick(hold - 4);
    endtask

    task automatic pulse_clear();
        faultClr = 1'b1;
        tick(1);
        faultClr = 1'b0;
        tick(2);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (nRst === 1'b1 && (stepValid === 1'b1 || stepErr === 1'b1)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_pulse: got valid=%0d err=%0d idx=%0d, expected no pulse",
                         stepValid, stepErr, stepIdx);
            end else begin
                e = sb.pop_front();
                $display("pulse idx=%0d dir=%0d valid=%0d err=%0d period=%0d", stepIdx, stepDir,
                         stepValid, stepErr, stepPeriod);
                check("pulse_valid", {31'd0, stepValid}, {31'd0, ~e.err});
                check("pulse_err", {31'd0, stepErr}, {31'd0, e.err});
                check("pulse_idx", {29'd0, stepIdx}, e.idx);
                check("pulse_dir", {31'd0, stepDir}, {31'd0, e.dir});
                check("pulse_stalled", {31'd0, stalled}, 32'd0);
                if (e.chk_period) check("pulse_period", {7'd0, stepPeriod}, e.period);
            end
        end
    end

    initial begin : watchdog
        #20_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        nRst = 1'b0;
        faultClr = 1'b0;
        g_hp = 3'b000;
        g_lp = 3'b000;
        tick(3);
        check("rst_idx", {29'd0, stepIdx}, 0);
        check("rst_period", {7'd0, stepPeriod}, 0);
        check("rst_flags", {26'd0, stepValid, stepErr, stepDir, stalled, faultShoot, faultDead}, 0);
        check("rst_phase", {29'd0, faultPhase}, 0);
        nRst = 1'b1;
        tick(8);

        // Forward 0..5..0, 1000 cycles per step including the Z gap.
        goto_step(0, 1000);
        for (int i = 1; i < 6; i++) begin
            push_exp(1'b0, i, 1'b0, 1000, i >= 2);
            goto_step(i, 1000);
        end
        push_exp(1'b0, 0, 1'b0, 1000, 1'b1);
        goto_step(0, 1000);
        check("fwd_no_shoot", {31'd0, faultShoot}, 0);
        check("fwd_no_dead", {31'd0, faultDead}, 0);

        // Jump into 3, reverse 3->2->1, then the non-adjacent 1->4.
        push_exp(1'b1, 3, 1'b0, 1000, 1'b1);
        goto_step(3, 200);
        push_exp(1'b0, 2, 1'b1, 200, 1'b1);
        goto_step(2, 200);
        push_exp(1'b0, 1, 1'b1, 200, 1'b1);
        goto_step(1, 200);
        push_exp(1'b1, 4, 1'b1, 200, 1'b1);
        goto_step(4, 200);
        check("err_idx_now", {29'd0, stepIdx}, 4);

        // Glitch: pattern 101 seen for 7 cycles (rejected), then 8 cycles (accepted).
        set_ph(0, PH_Z); tick(4);
        set_ph(0, PH_H); tick(3);
        set_ph(0, PH_Z); tick(4);
        set_ph(0, PH_L); tick(20);
        check("glitch7_idx", {29'd0, stepIdx}, 4);
        set_ph(0, PH_Z); tick(4);
        push_exp(1'b0, 5, 1'b0, 0, 1'b0);
        set_ph(0, PH_H); tick(4);
        set_ph(0, PH_Z); tick(4);
        push_exp(1'b0, 4, 1'b1, 8, 1'b1);
        set_ph(0, PH_L); tick(30);
        check("glitch_no_dead", {31'd0, faultDead}, 0);

        // Shoot-through on B, then clear coinciding with shoot-through on C.
        set_ph(1, PH_X); tick(1);
        set_ph(1, PH_L); tick(1);
        check("shoot_b_flag", {31'd0, faultShoot}, 1);
        check("shoot_b_phase", {29'd0, faultPhase}, 3'b010);
        check("shoot_b_nodead", {31'd0, faultDead}, 0);
        tick(5);
        check("shoot_b_sticky", {29'd0, faultPhase}, 3'b010);
        faultClr = 1'b1;
        set_ph(2, PH_X); tick(1);
        faultClr = 1'b0;
        set_ph(2, PH_H); tick(1);
        check("shoot_c_flag", {31'd0, faultShoot}, 1);
        check("shoot_c_phase", {29'd0, faultPhase}, 3'b100);
        pulse_clear();
        check("shoot_cleared", {28'd0, faultShoot, faultPhase}, 0);

        // Dead time on A: 3 Z cycles faults, 4 do not, direct swap faults.
        set_ph(0, PH_Z); tick(4);
        set_ph(0, PH_H); tick(1);
        set_ph(0, PH_Z); tick(3);
        set_ph(0, PH_L); tick(2);
        check("dead3_flag", {31'd0, faultDead}, 1);
        check("dead3_phase", {29'd0, faultPhase}, 3'b001);
        check("dead3_noshoot", {31'd0, faultShoot}, 0);
        pulse_clear();
        set_ph(0, PH_Z); tick(4);
        set_ph(0, PH_H); tick(1);
        set_ph(0, PH_Z); tick(4);
        set_ph(0, PH_L); tick(3);
        check("dead4_flag", {31'd0, faultDead}, 0);
        check("dead4_phase", {29'd0, faultPhase}, 0);
        set_ph(0, PH_Z); tick(4);
        set_ph(0, PH_H); tick(1);
        set_ph(0, PH_L); tick(2);
        check("dead0_flag", {31'd0, faultDead}, 1);
        check("dead0_phase", {29'd0, faultPhase}, 3'b001);
        pulse_clear();
        check("dead_cleared", {28'd0, faultDead, faultPhase}, 0);
        check("dead_idx_kept", {29'd0, stepIdx}, 4);

        // Stall: hold step 5 for 64 cycles with the threshold at 50.
        set_ph(0, PH_Z); tick(4);
        check("stall_before", {31'd0, stalled}, 1);
        push_exp(1'b0, 5, 1'b0, 0, 1'b0);
        set_ph(0, PH_H);
        tb_pat = 3'b101;
        tick(9);
        check("stall_accept_valid", {31'd0, stepValid}, 1);
        check("stall_accept_clear", {31'd0, stalled}, 0);
        tick(48);
        check("stall_cnt49", {31'd0, stalled}, 0);
        tick(1);
        check("stall_cnt50", {31'd0, stalled}, 1);
        tick(2);
        set_ph(2, PH_Z); tick(4);
        push_exp(1'b0, 0, 1'b0, 64, 1'b1);
        set_ph(2, PH_L);
        tb_pat = 3'b001;
        tick(30);
        check("stall_after_step", {31'd0, stalled}, 0);

        // Reset mid-run: everything clears and the next lock is silent.
        @(posedge clk); #20;
        nRst = 1'b0;
        #1;
        check("mid_rst_idx", {29'd0, stepIdx}, 0);
        check("mid_rst_period", {7'd0, stepPeriod}, 0);
        check("mid_rst_flags", {26'd0, stepValid, stepErr, stepDir, stalled, faultShoot, faultDead}, 0);
        check("mid_rst_phase", {29'd0, faultPhase}, 0);
        for (int ph = 0; ph < 3; ph++) set_ph(ph, PH_Z);
        tb_pat = 3'b000;
        tick(3);
        nRst = 1'b1;
        tick(6);
        goto_step(0, 100);
        check("post_rst_idx", {29'd0, stepIdx}, 0);
        check("post_rst_period", {7'd0, stepPeriod}, 0);
        push_exp(1'b0, 1, 1'b0, 100, 1'b1);
        goto_step(1, 100);
        tick(20);

        check("sb_drained", sb.size(), 0);
        check("end_no_faults", {29'd0, faultShoot, faultDead, stepErr}, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
